// File: rtl/if_fetch_unit_if.sv
// Instruction-memory fetch port: the fetch unit is the master, instruction memory the slave.
// Handshake: the master raises imem_req_out with a word address and holds both steady until
// imem_ack_in is sampled high; imem_data_in is valid in exactly that cycle (req && ack).
interface if_fetch_unit_if;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in;
    logic [31:0] imem_data_in;

    modport master (
        output imem_req_out,
        output imem_addr_out,
        input  imem_ack_in,
        input  imem_data_in
    );

    modport slave (
        input  imem_req_out,
        input  imem_addr_out,
        output imem_ack_in,
        output imem_data_in
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over the imem handshake and feeds IF_ID
// from a 2-entry {instruction, pc+4} buffer; redirects flush the buffer and restart fetch.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset_in,
    if_fetch_unit_if.master       imem,
    input  logic                  redirect_in,
    input  logic [31:0]           redirect_pc_in,
    input  logic                  stall_in,
    output logic                  valid_out,
    output logic [31:0]           Instruction_out,
    output logic [31:0]           PC_Counter_out,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t      state_q, state_n;
    logic [31:0] pc_q, pc_n;
    logic        req_q, req_n;
    logic [31:0] addr_q, addr_n;

    // Buffer is kept in order: slot 0 is always the head.
    logic        v0_q, v1_q, v0_n, v1_n;
    logic [31:0] instr0_q, instr1_q, instr0_n, instr1_n;
    logic [31:0] pc4_0_q, pc4_1_q, pc4_0_n, pc4_1_n;

    logic        ack;
    logic        pop;
    logic        push;
    logic        flush;
    logic [1:0]  count;
    logic [1:0]  count_pop;
    logic [31:0] pc_plus4;
    logic [31:0] target_pc;
    logic        rem0_v, rem1_v;
    logic [31:0] rem0_instr, rem0_pc4;
    logic        unused_low_bits;

    assign ack             = req_q & imem.imem_ack_in;
    assign pop             = v0_q & ~stall_in;
    assign pc_plus4        = pc_q + 32'd4;
    assign target_pc       = {redirect_pc_in[31:2], 2'b00};
    assign count           = {1'b0, v0_q} + {1'b0, v1_q};
    assign count_pop       = count - {1'b0, pop};
    assign unused_low_bits = ^redirect_pc_in[1:0];

    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        req_n   = req_q;
        addr_n  = addr_q;
        push    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (redirect_in) begin
                    flush   = 1'b1;
                    pc_n    = target_pc;
                    state_n = ST_WAIT;
                    req_n   = 1'b1;
                    addr_n  = target_pc;
                end else if (count_pop < 2'd2) begin
                    state_n = ST_WAIT;
                    req_n   = 1'b1;
                    addr_n  = pc_q;
                end
            end
            ST_WAIT: begin
                if (redirect_in) begin
                    flush = 1'b1;
                    pc_n  = target_pc;
                    if (ack) begin
                        addr_n = target_pc;
                    end else begin
                        state_n = ST_DROP;
                    end
                end else if (ack) begin
                    push = 1'b1;
                    pc_n = pc_plus4;
                    // After this push the buffer holds count_pop + 1 entries.
                    if (count_pop == 2'd0) begin
                        addr_n = pc_plus4;
                    end else begin
                        state_n = ST_IDLE;
                        req_n   = 1'b0;
                    end
                end
            end
            ST_DROP: begin
                if (redirect_in) begin
                    flush = 1'b1;
                    pc_n  = target_pc;
                end
                // The stale request completes here; its data is thrown away.
                if (ack) begin
                    state_n = ST_WAIT;
                    addr_n  = redirect_in ? target_pc : pc_q;
                end
            end
            default: begin
                state_n = ST_IDLE;
                req_n   = 1'b0;
            end
        endcase
    end

    always_comb begin
        rem0_v     = pop ? v1_q : v0_q;
        rem0_instr = pop ? instr1_q : instr0_q;
        rem0_pc4   = pop ? pc4_1_q : pc4_0_q;
        rem1_v     = pop ? 1'b0 : v1_q;
        v0_n       = rem0_v;
        v1_n       = rem1_v;
        instr0_n   = rem0_instr;
        pc4_0_n    = rem0_pc4;
        instr1_n   = instr1_q;
        pc4_1_n    = pc4_1_q;
        if (flush) begin
            v0_n = 1'b0;
            v1_n = 1'b0;
        end else if (push) begin
            if (!rem0_v) begin
                v0_n     = 1'b1;
                instr0_n = imem.imem_data_in;
                pc4_0_n  = pc_plus4;
            end else begin
                v1_n     = 1'b1;
                instr1_n = imem.imem_data_in;
                pc4_1_n  = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            v0_q     <= 1'b0;
            v1_q     <= 1'b0;
            instr0_q <= 32'h0;
            instr1_q <= 32'h0;
            pc4_0_q  <= 32'h0;
            pc4_1_q  <= 32'h0;
        end else begin
            state_q  <= state_n;
            pc_q     <= pc_n;
            req_q    <= req_n;
            addr_q   <= addr_n;
            v0_q     <= v0_n;
            v1_q     <= v1_n;
            instr0_q <= instr0_n;
            instr1_q <= instr1_n;
            pc4_0_q  <= pc4_0_n;
            pc4_1_q  <= pc4_1_n;
        end
    end

    assign imem.imem_req_out  = req_q;
    assign imem.imem_addr_out = addr_q;
    assign valid_out          = v0_q;
    assign Instruction_out    = instr0_q;
    assign PC_Counter_out     = pc4_0_q;
    assign state_dbg          = state_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed timing scenarios plus randomized memory latency,
// stalls and redirects, all checked against a transaction-level fetch-stream model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst2_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        valid, valid2;
  logic [31:0] instr, pc4, instr2, pc4_2;
  logic [1:0]  st_dbg, st2_dbg;

  if_fetch_unit_if bus ();
  if_fetch_unit_if bus2 ();

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .reset_in        (rst_n),
    .imem            (bus),
    .redirect_in     (redirect),
    .redirect_pc_in  (redirect_pc),
    .stall_in        (stall),
    .valid_out       (valid),
    .Instruction_out (instr),
    .PC_Counter_out  (pc4),
    .state_dbg       (st_dbg)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk             (clk),
    .reset_in        (rst2_n),
    .imem            (bus2),
    .redirect_in     (1'b0),
    .redirect_pc_in  (32'h0),
    .stall_in        (1'b0),
    .valid_out       (valid2),
    .Instruction_out (instr2),
    .PC_Counter_out  (pc4_2),
    .state_dbg       (st2_dbg)
  );

  // zero-wait memory returning the address as data
  assign bus2.imem_ack_in  = bus2.imem_req_out;
  assign bus2.imem_data_in = bus2.imem_addr_out;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- memory driver ----------------
  int mem_delay = 0;   // -1 selects a random 0..3 wait per request
  bit force_ack = 1'b0;
  int cur_wait, cur_lim;
  bit new_req = 1'b1;

  initial begin
    bus.imem_ack_in  = 1'b0;
    bus.imem_data_in = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (force_ack) begin
        bus.imem_ack_in  = 1'b1;
        bus.imem_data_in = 32'hDEAD_BEEF;
        new_req = 1'b1;
      end else if (!rst_n || !bus.imem_req_out) begin
        bus.imem_ack_in = 1'b0;
        new_req = 1'b1;
      end else begin
        if (new_req) begin
          cur_wait = 0;
          cur_lim  = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
          new_req  = 1'b0;
        end else begin
          cur_wait++;
        end
        bus.imem_ack_in = (cur_wait >= cur_lim);
        if (bus.imem_ack_in) new_req = 1'b1;
        bus.imem_data_in = bus.imem_addr_out;
      end
    end
  end

  // ---------------- reference model / scoreboard ----------------
  // The model tracks the architectural fetch stream: the next address that must be fetched,
  // the ordered list of delivered-but-unconsumed {instr, pc+4}, and whether the request on
  // the bus was overtaken by a redirect (its data must never appear).
  logic [63:0] exp_q[$];
  logic [63:0] exp_e;
  logic [31:0] exp_addr;
  bit          stale;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_addr = 32'h0000_0000;
      stale    = 1'b0;
    end else begin
      assert (exp_q.size() <= 2)
        else $error("FAIL fifo_overflow: got %0d entries expected at most 2", exp_q.size());
      check("valid_vs_model", {31'b0, valid}, {31'b0, exp_q.size() != 0});
      if (bus.imem_req_out) begin
        check("req_needs_room", {31'b0, exp_q.size() < 2}, 32'd1);
        check("addr_aligned", {30'b0, bus.imem_addr_out[1:0]}, 32'd0);
      end
      if (redirect) begin
        exp_q.delete();
        exp_addr = {redirect_pc[31:2], 2'b00};
        if (bus.imem_req_out) stale = 1'b1;
      end else if (valid && !stall && exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        check("head_instr", instr, exp_e[63:32]);
        check("head_pc4", pc4, exp_e[31:0]);
      end
      if (bus.imem_req_out && bus.imem_ack_in) begin
        if (stale) begin
          stale = 1'b0;
        end else begin
          check("fetch_addr", bus.imem_addr_out, exp_addr);
          exp_q.push_back({bus.imem_data_in, exp_addr + 32'd4});
          exp_addr = exp_addr + 32'd4;
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  logic [31:0] held;
  logic [31:0] wrap_addr_q[$];
  logic [31:0] wrap_pc_q[$];
  logic [31:0] wrap_addr_exp[3];
  logic [31:0] wrap_pc_exp[3];
  int          budget;

  initial begin
    rst_n       = 1'b0;
    rst2_n      = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall       = 1'b0;
    wrap_addr_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    wrap_pc_exp   = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    // reset values
    repeat (2) @(negedge clk);
    check("rst_req", {31'b0, bus.imem_req_out}, 32'd0);
    check("rst_addr", bus.imem_addr_out, 32'h0);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc4", pc4, 32'h0);

    // first-instruction latency and steady throughput
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("req_before_e0", {31'b0, bus.imem_req_out}, 32'd0);
    @(negedge clk);
    check("req_after_e0", {31'b0, bus.imem_req_out}, 32'd1);
    check("valid_after_e0", {31'b0, valid}, 32'd0);
    @(negedge clk);
    check("first_valid", {31'b0, valid}, 32'd1);
    check("first_instr", instr, 32'h0);
    check("first_pc4", pc4, 32'd4);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      check("stream_valid", {31'b0, valid}, 32'd1);
      check("stream_pc4", pc4, 32'(4 * k));
    end

    // stall held 5 cycles
    @(posedge clk); #1 stall = 1'b1;
    @(negedge clk);
    held = instr;
    repeat (4) @(negedge clk);
    check("stall_head", instr, held);
    check("stall_valid", {31'b0, valid}, 32'd1);
    check("stall_req_low", {31'b0, bus.imem_req_out}, 32'd0);
    @(posedge clk); #1 stall = 1'b0;
    @(negedge clk);
    check("unstall_req_still_low", {31'b0, bus.imem_req_out}, 32'd0);
    check("unstall_head0", instr, held);
    @(negedge clk);
    check("unstall_req_issued", {31'b0, bus.imem_req_out}, 32'd1);
    check("unstall_head1", instr, held + 32'd4);
    @(negedge clk);
    check("unstall_no_gap_valid", {31'b0, valid}, 32'd1);
    check("unstall_no_gap", instr, held + 32'd8);

    // redirect with ack in the same cycle, unaligned target
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h0000_0203;
    @(negedge clk);
    check("redir_ack_same_cycle", {31'b0, bus.imem_ack_in}, 32'd1);
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    check("redir_addr", bus.imem_addr_out, 32'h0000_0200);
    check("redir_req", {31'b0, bus.imem_req_out}, 32'd1);
    check("redir_flush", {31'b0, valid}, 32'd0);
    @(negedge clk);
    check("redir_first_valid", {31'b0, valid}, 32'd1);
    check("redir_first_pc4", pc4, 32'h0000_0204);

    // delayed ack, redirect on the first wait cycle
    @(negedge clk); #2 mem_delay = 3;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h0000_0100;
    @(negedge clk);
    check("drop_first_wait_no_ack", {31'b0, bus.imem_ack_in}, 32'd0);
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    check("drop_old_addr_held", bus.imem_addr_out, 32'h0);
    check("drop_req_held", {31'b0, bus.imem_req_out}, 32'd1);
    check("drop_flush", {31'b0, valid}, 32'd0);
    budget = 0;
    while (bus.imem_addr_out != 32'h100 && budget < 30) begin
      @(negedge clk);
      budget++;
    end
    check("drop_new_addr", bus.imem_addr_out, 32'h0000_0100);
    budget = 0;
    while (!valid && budget < 30) begin
      @(negedge clk);
      budget++;
    end
    check("drop_first_valid", {31'b0, valid}, 32'd1);
    check("drop_first_pc4", pc4, 32'h0000_0104);
    check("drop_first_instr", instr, 32'h0000_0100);

    // reset while a request is outstanding with one entry buffered
    @(negedge clk); #2 mem_delay = 2;
    @(posedge clk); #1 rst_n = 1'b0; stall = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    budget = 0;
    while (!valid && budget < 30) begin
      @(negedge clk);
      budget++;
    end
    check("mid_one_buffered", {31'b0, valid}, 32'd1);
    check("mid_req_outstanding", {31'b0, bus.imem_req_out}, 32'd1);
    #2 rst_n = 1'b0; force_ack = 1'b1;
    #1;
    check("mid_rst_req", {31'b0, bus.imem_req_out}, 32'd0);
    check("mid_rst_addr", bus.imem_addr_out, 32'h0);
    check("mid_rst_valid", {31'b0, valid}, 32'd0);
    check("mid_rst_instr", instr, 32'h0);
    check("mid_rst_pc4", pc4, 32'h0);
    @(negedge clk);
    check("mid_rst_ack_ignored", {31'b0, valid}, 32'd0);
    #2 force_ack = 1'b0; mem_delay = 0;
    @(posedge clk); #1 rst_n = 1'b1; stall = 1'b0;
    budget = 0;
    while (!valid && budget < 30) begin
      @(negedge clk);
      budget++;
    end
    check("mid_restart_instr", instr, 32'h0);
    check("mid_restart_pc4", pc4, 32'd4);

    // PC wrap on the second instance
    @(posedge clk); #1 rst2_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus2.imem_req_out && bus2.imem_ack_in) wrap_addr_q.push_back(bus2.imem_addr_out);
      if (valid2) wrap_pc_q.push_back(pc4_2);
    end
    check("wrap_addr_count", {31'b0, wrap_addr_q.size() >= 3}, 32'd1);
    check("wrap_pc_count", {31'b0, wrap_pc_q.size() >= 3}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (i < wrap_addr_q.size()) check("wrap_addr", wrap_addr_q[i], wrap_addr_exp[i]);
      if (i < wrap_pc_q.size()) check("wrap_pc4", wrap_pc_q[i], wrap_pc_exp[i]);
    end

    // randomized latency, stall and redirect
    @(negedge clk); #2 mem_delay = -1;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = $urandom;
    end
    @(posedge clk); #1 stall = 1'b0; redirect = 1'b0;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
